add_operand_feeder: RTL and testbench

ADD_OPERAND_FEEDER -- requirements
Module: add_operand_feeder

---
 rtl/add_operand_feeder.sv | 129 ++++++++++++
 tb/tb_add_operand_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_operand_feeder.sv
// Operand feeder for a combinational 4-bit adder.
// Operand pairs are queued in a small FIFO. The head pair is presented to an
// external adder. On each pop, the adder result and the operands are captured
// into a single-entry output stage.
// Each captured sum is also checked against an internally computed sum.
// Every disagreement is counted, saturating at 255, and latched into a sticky err flag.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// valid must not depend on ready. Once out_valid is raised, out_* hold until out_ready.
module add_operand_feeder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    output logic [3:0]               add_a,
    output logic [3:0]               add_b,
    input  logic [4:0]               add_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_a,
    output logic [3:0]               out_b,
    output logic [4:0]               out_sum,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               mismatch_cnt,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [3:0]    r_mem_a [DEPTH];
    logic [3:0]    r_mem_b [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_out_valid;
    logic [3:0]    r_out_a;
    logic [3:0]    r_out_b;
    logic [4:0]    r_out_sum;
    logic [7:0]    r_mismatch_cnt;
    logic          r_err;

    logic          w_not_empty;
    logic          w_push;
    logic          w_pop;
    logic [3:0]    w_head_a;
    logic [3:0]    w_head_b;
    logic [4:0]    w_exp_sum;
    logic          w_mismatch;

    // A full FIFO never accepts, even if it pops in the same cycle.
    assign w_not_empty = (r_count != '0);
    assign in_ready    = (r_count < FULL_CNT);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = w_not_empty && (!r_out_valid || out_ready);
    assign w_head_a    = r_mem_a[r_rd_ptr];
    assign w_head_b    = r_mem_b[r_rd_ptr];
    assign w_exp_sum   = {1'b0, w_head_a} + {1'b0, w_head_b};
    assign w_mismatch  = w_pop && (add_sum != w_exp_sum);

    // When the FIFO is empty, the adder inputs are zero so stale memory never reaches them.
    assign add_a        = w_not_empty ? w_head_a : 4'd0;
    assign add_b        = w_not_empty ? w_head_b : 4'd0;
    assign out_valid    = r_out_valid;
    assign out_a        = r_out_a;
    assign out_b        = r_out_b;
    assign out_sum      = r_out_sum;
    assign count        = r_count;
    assign mismatch_cnt = r_mismatch_cnt;
    assign err          = r_err;

    // Write the storage array. It is not reset, because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    // Update the pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: load on pop, drop on acceptance without refill, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_a     <= 4'd0;
            r_out_b     <= 4'd0;
            r_out_sum   <= 5'd0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_a     <= w_head_a;
            r_out_b     <= w_head_b;
            r_out_sum   <= add_sum;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Self-check bookkeeping: the mismatch counter saturates, and err stays set until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch_cnt <= 8'd0;
            r_err          <= 1'b0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
            if (r_mismatch_cnt != 8'hFF) r_mismatch_cnt <= r_mismatch_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_add_operand_feeder.sv
// Bench for add_operand_feeder.
// Stimulus comes from a hand-built vector table, hand-written corner sequences,
// and a random phase.
// Every cycle is compared against a queue-based model and a result scoreboard.
module tb_add_operand_feeder;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_a, in_b;
    logic [3:0]    add_a, add_b;
    logic [4:0]    add_sum;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_a, out_b;
    logic [4:0]    out_sum;
    logic [CW-1:0] count;
    logic [7:0]    mismatch_cnt;
    logic          err;
    logic          inject;

    int n_checks = 0;
    int n_errors = 0;
    int n_results = 0;

    // Model state: the pending pairs, the output stage, and the expected results in delivery order.
    logic [7:0]  mq[$];
    logic [12:0] exp_q[$];
    logic        m_ov;
    logic [3:0]  m_oa, m_ob;
    logic [4:0]  m_os;
    int          m_mis;
    logic        m_err;

    add_operand_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_sum(out_sum),
        .count(count), .mismatch_cnt(mismatch_cnt), .err(err)
    );

    // Clock and external adder. The adder can be made faulty for the pair (3,7).
    always #5 clk = ~clk;
    assign add_sum = {1'b0, add_a} + {1'b0, add_b}
                   + {4'd0, (inject && add_a == 4'd3 && add_b == 4'd7)};

    initial begin
        #1ms;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] bonus(input logic [3:0] a, input logic [3:0] b);
        return (inject && a == 4'd3 && b == 4'd7) ? 5'd1 : 5'd0;
    endfunction

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic rdy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        m_ov = 1'b0; m_oa = 4'd0; m_ob = 4'd0; m_os = 5'd0;
        m_mis = 0; m_err = 1'b0;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        inject = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_mismatch", mismatch_cnt, 0);
        check("rst_err", err, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance one clock edge with the current inputs, step the model, and compare.
    task automatic cycle();
        logic        accept, pop;
        logic [7:0]  h;
        logic [12:0] r;
        logic [4:0]  bn;
        if (m_ov && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                r = exp_q.pop_front();
                check("sb_out_a", out_a, r[12:9]);
                check("sb_out_b", out_b, r[8:5]);
                check("sb_out_sum", out_sum, r[4:0]);
                n_results++;
            end
        end
        accept = in_valid && (mq.size() < DEPTH);
        pop    = (mq.size() != 0) && (!m_ov || out_ready);
        if (pop) begin
            h    = mq.pop_front();
            bn   = bonus(h[7:4], h[3:0]);
            m_oa = h[7:4];
            m_ob = h[3:0];
            m_os = 5'(h[7:4]) + 5'(h[3:0]) + bn;
            m_ov = 1'b1;
            if (bn != 0) begin
                if (m_mis < 255) m_mis++;
                m_err = 1'b1;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        if (accept) begin
            mq.push_back({in_a, in_b});
            exp_q.push_back({in_a, in_b, 5'(in_a) + 5'(in_b) + bonus(in_a, in_b)});
        end
        @(posedge clk);
        #1;
        check("count", count, mq.size());
        check("in_ready", in_ready, (mq.size() < DEPTH) ? 1 : 0);
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("out_a", out_a, m_oa);
            check("out_b", out_b, m_ob);
            check("out_sum", out_sum, m_os);
        end
        check("add_a", add_a, (mq.size() != 0) ? mq[0][7:4] : 4'd0);
        check("add_b", add_b, (mq.size() != 0) ? mq[0][3:0] : 4'd0);
        check("mismatch_cnt", mismatch_cnt, m_mis);
        check("err", err, m_err);
    endtask

    typedef struct {
        logic       v;
        logic [3:0] a, b;
        logic       rdy;
        logic       e_ov;
        logic [4:0] e_sum;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int base;

        // Hand-computed vectors: (4,4) and (15,15) with one-cycle latency, then a stall that holds the output.
        tbl[0] = '{1'b1, 4'd4,  4'd4,  1'b1, 1'b0, 5'd0,  3'd1};
        tbl[1] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 5'd8,  3'd0};
        tbl[2] = '{1'b1, 4'd15, 4'd15, 1'b1, 1'b0, 5'd0,  3'd1};
        tbl[3] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 5'd30, 3'd0};
        tbl[4] = '{1'b1, 4'd0,  4'd0,  1'b0, 1'b1, 5'd30, 3'd1};
        tbl[5] = '{1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 5'd30, 3'd1};
        tbl[6] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 5'd0,  3'd0};
        tbl[7] = '{1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 5'd0,  3'd0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rdy);
            cycle();
            check("tbl_out_valid", out_valid, tbl[i].e_ov);
            check("tbl_count", count, tbl[i].e_cnt);
            if (tbl[i].e_ov) check("tbl_out_sum", out_sum, tbl[i].e_sum);
        end

        // Stalled output with six back-to-back pushes: five are accepted, and the first pair is held.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'(i + 1), 4'(i + 2), 1'b0);
            cycle();
        end
        check("fill_in_ready", in_ready, 0);
        check("fill_count", count, 4);
        check("fill_out_a", out_a, 1);
        check("fill_out_b", out_b, 2);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        repeat (6) cycle();
        check("fill_drained", exp_q.size(), 0);

        // Faulty adder on (3,7): one mismatch, then five correct pairs leave err set.
        do_reset();
        inject = 1'b1;
        drive(1'b1, 4'd3, 4'd7, 1'b1);
        cycle();
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        repeat (2) cycle();
        check("inj_mismatch", mismatch_cnt, 1);
        check("inj_err", err, 1);
        inject = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(i), 4'(i + 5), 1'b1);
            cycle();
        end
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        repeat (3) cycle();
        check("inj_err_sticky", err, 1);
        check("inj_mismatch_hold", mismatch_cnt, 1);

        // Asynchronous reset between edges, with three entries queued behind a held result.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i + 10), 4'(i), 1'b0);
            cycle();
        end
        check("pre_rst_count", count, 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        model_clear();
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) cycle();
        drive(1'b1, 4'd9, 4'd6, 1'b1);
        cycle();
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        cycle();
        check("arst_first_valid", out_valid, 1);
        check("arst_first_sum", out_sum, 15);
        check("arst_first_a", out_a, 9);
        cycle();

        // Continuous streaming of ten pairs across pointer wrap: occupancy settles at one.
        do_reset();
        base = n_results;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
            cycle();
            if (i > 0) check("stream_count", count, 1);
        end
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        repeat (3) cycle();
        check("stream_results", n_results - base, 10);

        // Mismatch counter saturation: stream 260 faulty pairs.
        do_reset();
        inject = 1'b1;
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 4'd3, 4'd7, 1'b1);
            cycle();
        end
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        repeat (3) cycle();
        check("sat_mismatch", mismatch_cnt, 255);
        inject = 1'b0;

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            cycle();
        end
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        repeat (8) cycle();
        check("rand_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
